ac_addsub_mw: RTL and testbench

Parametrised multi-word add/subtract/compare unit. It is the successor to the 8-bit accumulator add/sub stage and performs operations on operands of WIDTH×WORDS bits, one WIDTH-bit word per clock, least-significant word first. A carry register chains the word slices within an operation and, for ADC/SBC, across operations. Sign, zero, carry and overflow flags are committed at completion for the sequencer's branch logic.

---
 rtl/ac_addsub_mw.sv | 209 ++++++++++++++++++++
 tb/tb_ac_addsub_mw.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ac_addsub_mw.sv
// -----------------------------------------------------------------------------
// ac_addsub_mw
//   Multi-word add / subtract / compare unit. Operands of WIDTH*WORDS bits are
//   processed one WIDTH-bit word per clock, least-significant word first. A
//   working carry chains the slices inside an operation; the committed carry
//   flag chains operations together for ADC / SBC.
//
// Parameters
//   WIDTH   bits per word slice (adder width)
//   WORDS   word slices per operand (>= 1)
//
// Ports
//   clk     clock, all registers update on the rising edge
//   rst     asynchronous active-high reset
//   start   operation request, sampled only while idle
//   op      000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 CMP, 101-111 reserved
//   a, b    operands, latched when a request is accepted
//   busy    operation in progress (run cycles and the done cycle)
//   done    one-cycle completion pulse
//   result  result register (not updated by CMP)
//   sign    msb of the top result word
//   z       whole result is zero
//   c       final carry (for subtraction: 1 = no borrow)
//   v       signed overflow of the top word
//
// Configuration
//   AC_ADDSUB_MW_V_EN  defined: overflow detection present and v committed.
//                      undefined: no overflow logic, v is constant 0.
// -----------------------------------------------------------------------------
module ac_addsub_mw #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic [WIDTH*WORDS-1:0]   a,
   input  logic [WIDTH*WORDS-1:0]   b,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH*WORDS-1:0]   result,
   output logic                     sign,
   output logic                     z,
   output logic                     c,
   output logic                     v
);

   localparam int TOT = WIDTH * WORDS;
   localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_ADC = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_CMP = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [TOT-1:0]   r_a;
   logic [TOT-1:0]   r_b;        // already inverted for subtract-type ops
   logic [TOT-1:0]   r_stage;
   logic [TOT-1:0]   r_result;
   logic [KW-1:0]    r_k;
   logic             r_cw;
   logic             r_zacc;
   logic             r_cmp;
   logic             r_busy;
   logic             r_done;
   logic             r_sign;
   logic             r_z;
   logic             r_c;

   logic             w_accept;
   logic             w_op_legal;
   logic             w_inv_b;
   logic             w_cin;
   logic             w_last;
   logic [WIDTH-1:0] w_a_word;
   logic [WIDTH-1:0] w_b_word;
   logic [WIDTH:0]   w_sum;
   logic             w_s_zero;
   logic [TOT-1:0]   w_stage_next;

   // ---------------------------------------------------------------- decode
   assign w_op_legal = (op <= OP_CMP);
   assign w_inv_b    = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);

   always_comb begin
      w_cin = 1'b0;
      case (op)
         OP_SUB, OP_CMP: w_cin = 1'b1;
         OP_ADC, OP_SBC: w_cin = r_c;   // chain from the previous operation
         default:        w_cin = 1'b0;
      endcase
   end

   // ------------------------------------------------------------ word slice
   assign w_a_word = r_a[int'(r_k)*WIDTH +: WIDTH];
   assign w_b_word = r_b[int'(r_k)*WIDTH +: WIDTH];
   assign w_sum    = {1'b0, w_a_word} + {1'b0, w_b_word} + {{WIDTH{1'b0}}, r_cw};
   assign w_s_zero = (w_sum[WIDTH-1:0] == '0);
   assign w_last   = (r_k == KW'(WORDS-1));

   // Staging with the current word merged in, so the final word can be
   // committed to result on the same edge that enters DONE.
   always_comb begin
      w_stage_next = r_stage;
      w_stage_next[int'(r_k)*WIDTH +: WIDTH] = w_sum[WIDTH-1:0];
   end

`ifdef AC_ADDSUB_MW_V_EN
   logic r_v;
   logic w_ovf;
   // Signed overflow: operands agree in sign but the sum's sign differs.
   assign w_ovf = (w_a_word[WIDTH-1] == w_b_word[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != w_a_word[WIDTH-1]);
   assign v = r_v;
`else
   assign v = 1'b0;
`endif

   // --------------------------------------------------------------- FSM
   assign w_accept = (r_state == ST_IDLE) && start && w_op_legal;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (start && w_op_legal) w_state_next = ST_RUN;
         ST_RUN:  if (w_last)              w_state_next = ST_DONE;
         ST_DONE:                          w_state_next = ST_IDLE;
         default:                          w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Registered from next state so busy/done have no input-to-output path.
         r_busy  <= (w_state_next != ST_IDLE);
         r_done  <= (w_state_next == ST_DONE);
      end
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_stage  <= '0;
         r_result <= '0;
         r_k      <= '0;
         r_cw     <= 1'b0;
         r_zacc   <= 1'b0;
         r_cmp    <= 1'b0;
         r_sign   <= 1'b0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
`ifdef AC_ADDSUB_MW_V_EN
         r_v      <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_a    <= a;
            r_b    <= w_inv_b ? ~b : b;
            r_cmp  <= (op == OP_CMP);
            r_k    <= '0;
            r_cw   <= w_cin;
            r_zacc <= 1'b1;
         end else if (r_state == ST_RUN) begin
            r_stage <= w_stage_next;
            r_cw    <= w_sum[WIDTH];
            r_zacc  <= r_zacc & w_s_zero;
            r_k     <= r_k + 1'b1;
            if (w_last) begin
               // Commit on the edge into DONE: visible together with done=1.
               r_sign <= w_sum[WIDTH-1];
               r_z    <= r_zacc & w_s_zero;
               r_c    <= w_sum[WIDTH];
`ifdef AC_ADDSUB_MW_V_EN
               r_v    <= w_ovf;
`endif
               if (!r_cmp) begin
                  r_result <= w_stage_next;
               end
            end
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign sign   = r_sign;
   assign z      = r_z;
   assign c      = r_c;

endmodule

// File: tb/tb_ac_addsub_mw.sv
// -----------------------------------------------------------------------------
// tb_ac_addsub_mw
//   Self-checking bench for ac_addsub_mw (WIDTH=8, WORDS=4). Expected values
//   come from a whole-operand arithmetic model; v is expected only when the
//   overflow option macro is visible to this file as well.
// -----------------------------------------------------------------------------
module tb_ac_addsub_mw;

   localparam int WIDTH = 8;
   localparam int WORDS = 4;
`ifdef AC_ADDSUB_MW_V_EN
   localparam bit V_EN = 1'b1;
`else
   localparam bit V_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        sign;
   logic        z;
   logic        c;
   logic        v;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_res  = '0;
   logic        m_sign = 1'b0;
   logic        m_z    = 1'b0;
   logic        m_c    = 1'b0;
   logic        m_v    = 1'b0;

   ac_addsub_mw #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op_i),
      .a      (a_i),
      .b      (b_i),
      .busy   (busy),
      .done   (done),
      .result (result),
      .sign   (sign),
      .z      (z),
      .c      (c),
      .v      (v)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_result"}, result, m_res);
      check({tag, "_sign"},   sign,   m_sign);
      check({tag, "_z"},      z,      m_z);
      check({tag, "_c"},      c,      m_c);
      check({tag, "_v"},      v,      m_v);
   endtask

   // Whole-word arithmetic: A + B' + cin on 32 bits, flags from the 33-bit sum.
   task automatic model_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      logic [31:0] bp;
      logic        cin;
      logic [32:0] full;
      bp  = bv;
      cin = 1'b0;
      case (o)
         3'd0: begin bp = bv;  cin = 1'b0; end
         3'd1: begin bp = ~bv; cin = 1'b1; end
         3'd2: begin bp = bv;  cin = m_c;  end
         3'd3: begin bp = ~bv; cin = m_c;  end
         default: begin bp = ~bv; cin = 1'b1; end
      endcase
      full   = {1'b0, av} + {1'b0, bp} + {32'd0, cin};
      m_sign = full[31];
      m_z    = (full[31:0] == 32'd0);
      m_c    = full[32];
      m_v    = V_EN && (av[31] == bp[31]) && (full[31] != av[31]);
      if (o != 3'd4) m_res = full[31:0];
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit hold);
      int n;
      int dones;
      @(negedge clk);
      start = 1'b1; op_i = o; a_i = av; b_i = bv;
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (o > 3'd4) begin
         start = 1'b0;
         check("rsv_busy", busy, 1'b0);
         dones = 0;
         repeat (8) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) dones++;
         end
         check("rsv_done", dones, 0);
         check_outputs("rsv");
         $display("op=%0d a=%h b=%h reserved: ignored", o, av, bv);
         return;
      end
      check("busy_run", busy, 1'b1);
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, WORDS + 1);
      check("busy_done", busy, 1'b1);
      start = 1'b0;
      model_op(o, av, bv);
      check_outputs("op");
      $display("op=%0d a=%h b=%h -> result=%h s=%b z=%b c=%b v=%b", o, av, bv,
               result, sign, z, c, v);
      dones = 0;
      repeat (WORDS + 4) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("extra_done", dones, 0);
      check("idle_busy", busy, 1'b0);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [4];
      specials[0] = 32'h0000_0000;
      specials[1] = 32'hFFFF_FFFF;
      specials[2] = 32'h7FFF_FFFF;
      specials[3] = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
      repeat (3) @(negedge clk);
      check_outputs("reset");
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      rst = 1'b0;

      // carry across word boundary
      run_op(3'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      check("plan_carry", result, 32'h0000_0100);
      // borrow
      run_op(3'd1, 32'h0000_0000, 32'h0000_0001, 1'b0);
      check("plan_borrow", result, 32'hFFFF_FFFF);
      // chained ADC
      run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(3'd2, 32'h0000_0000, 32'h0000_0000, 1'b0);
      check("plan_adc", result, 32'h0000_0001);
      // overflow then CMP keeping result
      run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(3'd4, 32'h1234_5678, 32'h1234_5678, 1'b0);
      check("plan_cmp_keep", result, 32'h8000_0000);
      // start held during RUN, reserved op
      run_op(3'd0, 32'h0000_1111, 32'h0000_2222, 1'b1);
      run_op(3'd6, 32'h0000_0001, 32'h0000_0001, 1'b0);

      // reset in the middle of an operation
      @(negedge clk);
      start = 1'b1; op_i = 3'd0; a_i = 32'h0000_0010; b_i = 32'h0000_0020;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      m_res = '0; m_sign = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
      check_outputs("midrst");
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      $display("reset asserted mid-operation");
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) dones++;
      end
      check("midrst_no_done", dones, 0);
      run_op(3'd0, 32'd2, 32'd3, 1'b0);
      check("plan_after_rst", result, 32'd5);

      // randomized operations
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
